spi_flash_arbiter: RTL
======================

# spi_flash_arbiter

Two-port request arbiter and sequencer in front of `SPIFlashModule`. It lets the instruction-fetch port (read-only) and the data port (read/write) share the single flash controller. It grants one request at a time with round-robin fairness and drives the controller's `io_flash_*` command inputs. It tracks completion through `io_state_to_cpu`, then returns read data and status to the granted requester, with a timeout guard against a hung flash.

## Interface
- `IDLE_CODE`, default 12'h000: value of `io_state_to_cpu` when the flash controller is idle.
- `TIMEOUT_CYCLES`, default 4096: maximum cycles from command issue to completion before error abort; width = clog2(TIMEOUT_CYCLES+1).
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 forces reset state immediately.
- `io_i_req_valid`  in  1  fetch request; held stable until `io_i_req_ready`.
- `io_i_req_addr`  in  24  fetch byte address.
- `io_i_req_ready`  out  1  fetch request accepted this cycle.
- `io_i_resp_valid`  out  1  one-cycle fetch response pulse.
- `io_d_req_valid`  in  1  data request; held stable until `io_d_req_ready`.
- `io_d_req_write`  in  1  1 = write, 0 = read.
- `io_d_req_addr`  in  24  data byte address.
- `io_d_req_wdata`  in  32  write data.
- `io_d_req_ready`  out  1  data request accepted this cycle.
- `io_d_resp_valid`  out  1  one-cycle data response pulse.
- `io_resp_rdata`  out  32  read data, shared by both ports; valid with either resp_valid.
- `io_resp_err`  out  1  timeout error; valid with either resp_valid.
- `io_quad_mode`  in  4  quad-IO configuration; latched at grant.
- `io_flash_en`, `io_flash_write`  out  1 each  to controller.
- `io_quad_io`  out  4  to controller.
- `io_flash_addr`  out  24  to controller.
- `io_flash_data_in`  out  32  to controller.
- `io_flash_data_out`  in  32  from controller.
- `io_state_to_cpu`  in  12  controller state.
- `io_busy`  out  1  high whenever FSM is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, RESP.
- **IDLE**
  - With no valid request, nothing happens.
  - With one valid request, that port is granted.
  - With both valid, the port not granted last wins. The last-grant flag resets to "data", so fetch wins the first tie.
  - Grant is combinational: `req_ready` of the winner is high that cycle.
  - At the edge, the arbiter latches addr, write (0 for fetch), wdata, `io_quad_mode` and the owner into command registers, then moves to ISSUE.
  - Exactly one ready is ever high.
- **ISSUE**
  - `io_flash_en`=1; command registers drive the controller.
  - When `io_state_to_cpu != IDLE_CODE` is sampled, drop en and move to WAIT_DONE.
- **WAIT_DONE**
  - `io_flash_en`=0, command outputs hold.
  - When `io_state_to_cpu == IDLE_CODE` is sampled: capture `io_flash_data_out` into rdata (reads only; writes load 0) with err=0, then move to RESP.
- **RESP**
  - The owner's resp_valid is high for exactly one cycle; the other port's resp_valid stays 0.
  - Then return to IDLE.
  - No request is accepted in RESP.
- **Timeout**
  - Counter clears on entering ISSUE and increments each cycle in ISSUE or WAIT_DONE.
  - On reaching TIMEOUT_CYCLES, the FSM goes to RESP with err=1, rdata=0 and en dropped, whatever the current state.
  - A completion seen in the same cycle as expiry takes priority: err=0.
- New requests arriving while busy wait; their valid/addr must stay held.

## Timing
- Reset values:
  - state IDLE; all readies, resp_valids, `io_flash_en`, `io_flash_write`, `io_busy` = 0.
  - `io_flash_addr`, `io_flash_data_in`, `io_resp_rdata` = 0; `io_quad_io` = 0; `io_resp_err` = 0; last-grant = data.
- Reset mid-operation drops `io_flash_en` asynchronously; the pending request is lost with no response.
- Latency: accept at cycle 0; en high from cycle 1. If the controller leaves idle after B cycles of en and stays busy D cycles, resp_valid is at cycle 1+B+D+1.
- Minimum accept-to-accept spacing is 4 cycles (IDLE, ISSUE, WAIT_DONE, RESP).
- All outputs except the readies are registered; the readies depend on the valids and the state only.

## Test plan
- Fetch read: controller model busy 5 cycles after en, data_out=32'hDEADBEEF.
  - Expect `io_i_req_ready` at cycle 0, en high cycle 1 only until busy is seen.
  - Expect `io_i_resp_valid` with rdata 32'hDEADBEEF and err=0; `io_d_resp_valid` stays 0.
- Data write to 24'h00_1000 with wdata 32'h12345678.
  - Expect `io_flash_write`=1, addr/data driven during ISSUE.
  - Expect `io_d_resp_valid` with rdata 0 and err=0.
- Both ports valid every cycle for 6 transactions: grants alternate I, D, I, D, I, D, and readies are never high together.
- Controller never leaves IDLE_CODE with TIMEOUT_CYCLES=16: resp_valid 16 cycles after ISSUE entry, err=1, rdata=0, en=0 afterwards.
- Assert reset low in WAIT_DONE: en, busy and resp_valid are 0 immediately. After release, a fetch-only request is granted normally and a tie goes to fetch first.
- Completion coincides with timeout expiry: err=0 and rdata equals `io_flash_data_out`.

Source files
------------

// File: rtl/spi_flash_arbiter_if.sv
// Bundle of all request/response and flash-controller signals around spi_flash_arbiter.
//   slave  : arbiter view (takes requests, drives responses and the controller command inputs)
//   master : environment view (requesters plus the flash controller model)
// Request side : io_i_req_*, io_d_req_*, io_quad_mode  (into the arbiter)
// Response side: io_*_req_ready, io_*_resp_valid, io_resp_rdata, io_resp_err, io_busy
// Flash side   : io_flash_en/write/addr/data_in, io_quad_io  (out of the arbiter)
//                io_flash_data_out, io_state_to_cpu         (into the arbiter)
interface spi_flash_arbiter_if;
  logic        io_i_req_valid;
  logic [23:0] io_i_req_addr;
  logic        io_i_req_ready;
  logic        io_i_resp_valid;

  logic        io_d_req_valid;
  logic        io_d_req_write;
  logic [23:0] io_d_req_addr;
  logic [31:0] io_d_req_wdata;
  logic        io_d_req_ready;
  logic        io_d_resp_valid;

  logic [31:0] io_resp_rdata;
  logic        io_resp_err;
  logic [3:0]  io_quad_mode;

  logic        io_flash_en;
  logic        io_flash_write;
  logic [3:0]  io_quad_io;
  logic [23:0] io_flash_addr;
  logic [31:0] io_flash_data_in;
  logic [31:0] io_flash_data_out;
  logic [11:0] io_state_to_cpu;
  logic        io_busy;

  modport slave (
    input  io_i_req_valid, io_i_req_addr,
    input  io_d_req_valid, io_d_req_write, io_d_req_addr, io_d_req_wdata,
    input  io_quad_mode, io_flash_data_out, io_state_to_cpu,
    output io_i_req_ready, io_i_resp_valid, io_d_req_ready, io_d_resp_valid,
    output io_resp_rdata, io_resp_err,
    output io_flash_en, io_flash_write, io_quad_io, io_flash_addr, io_flash_data_in,
    output io_busy
  );

  modport master (
    output io_i_req_valid, io_i_req_addr,
    output io_d_req_valid, io_d_req_write, io_d_req_addr, io_d_req_wdata,
    output io_quad_mode, io_flash_data_out, io_state_to_cpu,
    input  io_i_req_ready, io_i_resp_valid, io_d_req_ready, io_d_resp_valid,
    input  io_resp_rdata, io_resp_err,
    input  io_flash_en, io_flash_write, io_quad_io, io_flash_addr, io_flash_data_in,
    input  io_busy
  );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Two-port (fetch read-only, data read/write) arbiter and sequencer in front of a single
// SPI flash controller. Round-robin grant, one command in flight, completion tracked via
// io_state_to_cpu, timeout abort against a hung controller.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : spi_flash_arbiter_if.slave (requests, responses, controller command/status)
module spi_flash_arbiter #(
  parameter logic [11:0] IDLE_CODE      = 12'h000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic               clk,
  input logic               reset,
  spi_flash_arbiter_if.slave bus
);

  localparam int unsigned       TimerW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StResp} state_e;

  state_e              state_q;
  logic                last_data_q;   // 1: data port was granted last
  logic                owner_data_q;  // 1: current command belongs to the data port
  logic [TimerW-1:0]   timer_q;
  logic [23:0]         addr_q;
  logic                write_q;
  logic [31:0]         wdata_q;
  logic [3:0]          quad_q;
  logic                en_q;
  logic                busy_q;
  logic                i_resp_q;
  logic                d_resp_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic              grant_i;
  logic              grant_d;
  logic              ctrl_idle;
  logic              in_flight;
  logic              done_ok;
  logic              expired;
  logic [TimerW-1:0] timer_inc;

  assign ctrl_idle = (bus.io_state_to_cpu == IDLE_CODE);
  assign in_flight = (state_q == StIssue) || (state_q == StWaitDone);
  assign timer_inc = timer_q + 1'b1;
  // Completion wins over a coincident timeout.
  assign done_ok   = (state_q == StWaitDone) && ctrl_idle;
  assign expired   = in_flight && (timer_inc == TimerMax);

  // Grant only in IDLE; on a tie the port that did not win last time goes first.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == StIdle) begin
      grant_i = bus.io_i_req_valid && (!bus.io_d_req_valid || last_data_q);
      grant_d = bus.io_d_req_valid && !grant_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_data_q  <= 1'b1;
      owner_data_q <= 1'b0;
      timer_q      <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      quad_q       <= '0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_i || grant_d) begin
            owner_data_q <= grant_d;
            last_data_q  <= grant_d;
            addr_q       <= grant_d ? bus.io_d_req_addr : bus.io_i_req_addr;
            write_q      <= grant_d && bus.io_d_req_write;
            wdata_q      <= grant_d ? bus.io_d_req_wdata : '0;
            quad_q       <= bus.io_quad_mode;
            timer_q      <= '0;
            en_q         <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue, StWaitDone: begin
          timer_q <= timer_inc;
          if (done_ok || expired) begin
            state_q  <= StResp;
            en_q     <= 1'b0;
            i_resp_q <= !owner_data_q;
            d_resp_q <= owner_data_q;
            err_q    <= !done_ok;
            rdata_q  <= (done_ok && !write_q) ? bus.io_flash_data_out : '0;
          end else if (state_q == StIssue && !ctrl_idle) begin
            // Controller has picked up the command.
            en_q    <= 1'b0;
            state_q <= StWaitDone;
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.io_i_req_ready   = grant_i;
  assign bus.io_d_req_ready   = grant_d;
  assign bus.io_i_resp_valid  = i_resp_q;
  assign bus.io_d_resp_valid  = d_resp_q;
  assign bus.io_resp_rdata    = rdata_q;
  assign bus.io_resp_err      = err_q;
  assign bus.io_flash_en      = en_q;
  assign bus.io_flash_write   = write_q;
  assign bus.io_quad_io       = quad_q;
  assign bus.io_flash_addr    = addr_q;
  assign bus.io_flash_data_in = wdata_q;
  assign bus.io_busy          = busy_q;

endmodule
